rom_stream_reader: RTL and testbench

Streaming read front-end for `single_port_rom`. It accepts a job (base address, length), drives the ROM's `en`/`address` port, and captures each byte one cycle after the request. Bytes go into a 2-entry output buffer. They leave on a valid/ready stream with a last-beat marker. It sits directly upstream of the ROM's address port and downstream of its `data_out`. It converts the ROM's fixed-latency read into a back-pressurable byte stream for the rest of the memory bank.

---
 rtl/rom_stream_reader.sv | 167 ++++++++++++++++
 tb/tb_rom_stream_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Streaming front-end for a 1-cycle-latency ROM: issues reads for a (base, len) job and
// drains them through a 2-entry buffer onto a valid/ready byte stream.
// Optional ROM_READER_CSUM_EN adds a running checksum of handshaken beats on csum.
module rom_stream_reader #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              done,
  output logic [DATA_W-1:0] csum
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | issuing reads and/or draining the buffer
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [ADDR_W-1:0]           last_addr_q, last_addr_d;
  logic [ADDR_W:0]             rem_q, rem_d;
  logic [ADDR_W:0]             len_q, len_d;
  logic [ADDR_W:0]             beat_q, beat_d;
  logic                        pend_q, pend_d;
  logic [1:0][DATA_W-1:0]      fdata_q, fdata_d;
  logic [1:0]                  flast_q, flast_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic                        wr_ptr_q, wr_ptr_d;
  logic [1:0]                  cnt_q, cnt_d;

  logic       pop;
  logic       issue;
  logic [2:0] in_flight;

  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = fdata_q[rd_ptr_q];
  assign m_last  = m_valid & flast_q[rd_ptr_q];
  assign pop     = m_valid & m_ready;

  // Beats buffered plus the one landing this edge, net of this cycle's pop, must leave a free slot.
  assign in_flight = 3'(cnt_q) + 3'(pend_q) - 3'(pop);
  assign issue     = (state_q == READ) && (rem_q != '0) && (in_flight < 3'd2);

  assign rom_en   = issue;
  assign rom_addr = issue ? addr_q : last_addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    rem_d       = rem_q;
    len_d       = len_q;
    beat_d      = beat_q;
    pend_d      = issue;
    fdata_d     = fdata_q;
    flast_d     = flast_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = len;
          len_d   = len;
          beat_d  = '0;
          state_d = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (pop && m_last) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      addr_d      = addr_q + ADDR_ONE;
      rem_d       = rem_q - CNT_ONE;
      last_addr_d = addr_q;
    end

    if (pend_q) begin
      fdata_d[wr_ptr_q] = rom_data;
      flast_d[wr_ptr_q] = ((beat_q + CNT_ONE) == len_q);
      wr_ptr_d          = ~wr_ptr_q;
      beat_d            = beat_q + CNT_ONE;
    end

    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({pend_q, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      pend_q      <= 1'b0;
      fdata_q     <= '0;
      flast_q     <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      pend_q      <= pend_d;
      fdata_q     <= fdata_d;
      flast_q     <= flast_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef ROM_READER_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start) csum_d = '0;
    else if (pop)                 csum_d = csum_q + m_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader: jobs push expected beats, a negedge monitor
// pops and compares every handshake; directed and random jobs with varied back-pressure.
module tb_rom_stream_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] base_addr;
  logic [3:0] len;
  logic       busy;
  logic       rom_en;
  logic [2:0] rom_addr;
  logic [7:0] rom_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       done;
  logic [7:0] csum;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  logic [7:0] rom_mem [8];
  int issued, popped, job_pops;
  bit prev_stall;
  logic [7:0] prev_data;
  logic prev_last;

  rom_stream_reader #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .done(done), .csum(csum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int a = 0; a < 8; a++) rom_mem[a] = 8'hA0 + 8'(a);
    rom_data = 8'h00;
  end

  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      issued     = 0;
      popped     = 0;
      prev_stall = 1'b0;
    end else begin
      chk("outstanding_le2", int'((issued - popped) <= 2), 1);
      if (prev_stall) begin
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_data", int'(m_data), int'(prev_data));
        chk("stall_last", int'(m_last), int'(prev_last));
      end
      if (m_valid && m_ready) begin
        chk("beat_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("beat_data", int'(m_data), int'(e[7:0]));
          chk("beat_last", int'(m_last), int'(e[8]));
        end
        popped++;
        job_pops++;
      end
      if (rom_en) issued++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // mode 0: ready always high, 1: 5-cycle stall then toggling, 2: random ready
  task automatic run_job(input int b, input int l, input int mode, input bit mid_start);
    int n, first_v, done_n;
    bit saw_en, saw_v;
    logic [7:0] sum, exp_csum, held;
    sum = 8'h00;
    for (int i = 0; i < l; i++) begin
      logic [7:0] d;
      d = 8'hA0 + 8'((b + i) % 8);
      exp_q.push_back({(i == l - 1), d});
      sum = sum + d;
    end
`ifdef ROM_READER_CSUM_EN
    exp_csum = sum;
`else
    exp_csum = 8'h00;
`endif
    start     = 1'b1;
    base_addr = 3'(b);
    len       = 4'(l);
    m_ready   = (mode == 0);
    @(posedge clk);
    #1;
    start   = 1'b0;
    n       = 0;
    first_v = -1;
    done_n  = done ? 0 : -1;
    saw_en  = rom_en;
    saw_v   = m_valid;
    chk("busy_after_start", int'(busy), 1);
    while (done_n < 0 && n < 300) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (first_v < 0 || n < first_v + 5) ? 1'b0 : 1'(((n - first_v) % 2) == 1);
        default: m_ready = 1'($urandom % 2);
      endcase
      if (mid_start) begin
        start     = (n == 3);
        base_addr = 3'd5;
        len       = 4'd2;
      end
      @(posedge clk);
      #1;
      n++;
      if (rom_en) saw_en = 1'b1;
      if (m_valid) begin
        saw_v = 1'b1;
        if (first_v < 0) first_v = n;
      end
      if (mode == 1 && first_v >= 0 && n == first_v + 4)
        chk("stall_rom_en_low", int'(rom_en), 0);
      if (done) done_n = n;
    end
    start = 1'b0;
    chk("done_seen", int'(done_n >= 0), 1);
    if (mode == 0) begin
      if (l > 0) begin
        chk("first_beat_latency", first_v, 2);
        chk("done_cycle", done_n, l + 2);
      end else begin
        chk("len0_done_cycle", done_n, 0);
      end
    end
    if (l == 0) begin
      chk("len0_rom_en", int'(saw_en), 0);
      chk("len0_m_valid", int'(saw_v), 0);
    end
    chk("csum_at_done", int'(csum), int'(exp_csum));
    chk("all_beats_seen", exp_q.size(), 0);
    held = csum;
    @(posedge clk);
    #1;
    chk("busy_fall", int'(busy), 0);
    chk("done_one_cycle", int'(done), 0);
    chk("csum_hold", int'(csum), int'(held));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_rom_en"}, int'(rom_en), 0);
    chk({tag, "_rom_addr"}, int'(rom_addr), 0);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_m_data"}, int'(m_data), 0);
    chk({tag, "_m_last"}, int'(m_last), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_csum"}, int'(csum), 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = 3'd0;
    len       = 4'd0;
    m_ready   = 1'b0;
    job_pops  = 0;
    #2;
    chk_all_zero("reset");
    #20;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_job(0, 8, 0, 1'b0);
    run_job(6, 4, 0, 1'b0);
    run_job(2, 6, 1, 1'b0);
    run_job(0, 0, 0, 1'b0);
    run_job(0, 8, 0, 1'b1);

    // reset in the middle of a job after three beats have handshaken
    job_pops = 0;
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 8'hA0 + 8'(i)});
    start     = 1'b1;
    base_addr = 3'd0;
    len       = 4'd8;
    m_ready   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 50 && job_pops < 3; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pops_before_reset", job_pops, 3);
    rst = 1'b1;
    #1;
    chk_all_zero("midjob_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all_zero("post_reset");
    run_job(1, 2, 0, 1'b0);

    for (int j = 0; j < 10; j++)
      run_job(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)), 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
